alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: flush  input  1  synchronous discard of all buffered entries.
REQ-004 SHALL have port: in_valid  input  1  upstream entry present.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an entry this cycle.
REQ-006 SHALL have port: inst  input  32  MIPS instruction word.
REQ-007 SHALL have port: rs_data  input  32  register-file read value for inst[25:21].
REQ-008 SHALL have port: rt_data  input  32  register-file read value for inst[20:16].
REQ-009 SHALL have port: out_valid  output  1  head entry presented to the ALU.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes the head entry.
REQ-011 SHALL have port: A  output  32  ALU operand A.
REQ-012 SHALL have port: B  output  32  ALU operand B.
REQ-013 SHALL have port: ALUop  output  3  ALU opcode (000 and, 001 or, 010 add, 110 sub, 111 slt).
REQ-014 SHALL have ports: dest  output  5  writeback register; wen  output  1  writeback enable; illegal  output  1  undecodable instruction.

Function
REQ-015 SHALL decode opcode 000000 by funct: 100000/100001 -> 010; 100010/100011 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; then B=rt_data, dest=inst[15:11].
REQ-016 SHALL decode I-type: 001001 addiu -> 010 with sign-extended imm; 001010 slti -> 111 with sign-extended imm; 001100 andi -> 000 with zero-extended imm; 001101 ori -> 001 with zero-extended imm; then B=extended imm, dest=inst[20:16].
REQ-017 SHALL set A=rs_data for every legal instruction.
REQ-018 SHALL set wen=1 for a legal entry and wen=0 when dest==0.
REQ-019 SHALL encode any other opcode/funct as: illegal=1, wen=0, ALUop=010, A=0, B=0, dest=0.
REQ-020 SHALL hold decoded entries {A,B,ALUop,dest,wen,illegal} in a 2-entry FIFO buffer with count 0..2.
REQ-021 SHALL drive in_ready=1 iff count<2; push occurs iff in_valid&in_ready.
REQ-022 SHALL drive out_valid=1 iff count>0; pop occurs iff out_valid&out_ready; outputs show the head entry combinationally from buffer registers.
REQ-023 SHALL make an entry pushed at edge k visible on the outputs in cycle k+1 when the buffer was empty (latency 1).
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and keep order (popped head replaced by next entry, new entry appended).
REQ-025 SHALL preserve FIFO order; no entry is dropped or duplicated without flush.
REQ-026 SHALL hold outputs stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on flush=1, set count=0 at the next edge, ignoring any concurrent push and pop.
REQ-028 SHALL drive A, B, ALUop, dest, wen, illegal to all-zero whenever count=0.

Reset
REQ-029 SHALL, while resetn=0, immediately force count=0, out_valid=0, all entry registers to 0, and in_ready=1 after release.
REQ-030 SHALL discard any buffered entries on reset asserted mid-operation; no entry is output after release until a new push.

Verification
REQ-031 Reset then push addu $3,$1,$2 (rs=5, rt=7), out_ready=1 -> next cycle out_valid=1, A=5, B=7, ALUop=010, dest=3, wen=1.
REQ-032 Push addiu $4,$0,0xFFFF (rs=0) -> B=0xFFFFFFFF, ALUop=010, dest=4; ori with 0xFFFF -> B=0x0000FFFF, ALUop=001.
REQ-033 Hold out_ready=0, push 3 entries -> third stalls with in_ready=0, count=2, head stable; raise out_ready -> entries emerge in order.
REQ-034 With count=1, push and pop in the same cycle -> count stays 1, next head is the new entry.
REQ-035 Push opcode 111111 -> illegal=1, wen=0, A=0, B=0; then flush with in_valid=1 -> out_valid=0 next cycle.
REQ-036 Assert resetn=0 asynchronously with count=2 -> out_valid=0 before the next clock edge, in_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage for a small MIPS integer pipeline: decodes ALU instructions into
// operand/opcode bundles and buffers them in a 2-entry FIFO ahead of the ALU.
module alu_issue_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALUop,
    output logic [4:0]  dest,
    output logic        wen,
    output logic        illegal
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  alu_op;
        logic [4:0]  dest;
        logic        wen;
        logic        illegal;
    } entry_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        dec_legal;
    logic [2:0]  dec_op;
    logic [31:0] dec_b;
    logic [4:0]  dec_dest;
    entry_t      dec_entry;
    entry_t      head;
    logic        push;
    logic        pop;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_b     = '0;
        dec_dest  = '0;
        case (inst[31:26])
            6'b000000: begin
                dec_b     = rt_data;
                dec_dest  = inst[15:11];
                dec_legal = 1'b1;
                case (inst[5:0])
                    6'b100000, 6'b100001: dec_op = OP_ADD;
                    6'b100010, 6'b100011: dec_op = OP_SUB;
                    6'b100100:            dec_op = OP_AND;
                    6'b100101:            dec_op = OP_OR;
                    6'b101010:            dec_op = OP_SLT;
                    default:              dec_legal = 1'b0;
                endcase
            end
            6'b001001: begin
                dec_legal = 1'b1;
                dec_op    = OP_ADD;
                dec_b     = {{16{inst[15]}}, inst[15:0]};
                dec_dest  = inst[20:16];
            end
            6'b001010: begin
                dec_legal = 1'b1;
                dec_op    = OP_SLT;
                dec_b     = {{16{inst[15]}}, inst[15:0]};
                dec_dest  = inst[20:16];
            end
            6'b001100: begin
                dec_legal = 1'b1;
                dec_op    = OP_AND;
                dec_b     = {16'h0000, inst[15:0]};
                dec_dest  = inst[20:16];
            end
            6'b001101: begin
                dec_legal = 1'b1;
                dec_op    = OP_OR;
                dec_b     = {16'h0000, inst[15:0]};
                dec_dest  = inst[20:16];
            end
            default: dec_legal = 1'b0;
        endcase

        // Undecodable words become a harmless add of zeros flagged as illegal.
        dec_entry         = '0;
        dec_entry.alu_op  = OP_ADD;
        dec_entry.illegal = 1'b1;
        if (dec_legal) begin
            dec_entry.a       = rs_data;
            dec_entry.b       = dec_b;
            dec_entry.alu_op  = dec_op;
            dec_entry.dest    = dec_dest;
            dec_entry.wen     = (dec_dest != 5'd0);
            dec_entry.illegal = 1'b0;
        end
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Outputs read zero while empty so stale flushed entries never leak out.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign A       = head.a;
    assign B       = head.b;
    assign ALUop   = head.alu_op;
    assign dest    = head.dest;
    assign wen     = head.wen;
    assign illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, FIFO stall/order,
// flush and asynchronous reset behaviour.
module tb_alu_issue_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUop;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;

    int tests_run;
    int tests_failed;

    // {out_valid, A, B, ALUop, dest, wen, illegal}
    logic [74:0] obs;
    assign obs = {out_valid, A, B, ALUop, dest, wen, illegal};

    alu_issue_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .dest      (dest),
        .wen       (wen),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [74:0] mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic [4:0] d,
                                       input logic w, input logic il);
        return {v, a, b, op, d, w, il};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [74:0] exp;
    } vec_t;

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ordy);
        in_valid  = v;
        inst      = i;
        rs_data   = rs;
        rt_data   = rt;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        tests_run++;
        if (obs !== 75'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 75'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_stream();
        vec_t v [10];
        v[0] = '{r_type(5'd1, 5'd2, 5'd3, 6'b100001), 32'd5, 32'd7,
                 mk(1'b1, 32'd5, 32'd7, 3'b010, 5'd3, 1'b1, 1'b0)};
        v[1] = '{r_type(5'd1, 5'd2, 5'd5, 6'b100010), 32'd10, 32'd3,
                 mk(1'b1, 32'd10, 32'd3, 3'b110, 5'd5, 1'b1, 1'b0)};
        v[2] = '{r_type(5'd1, 5'd2, 5'd6, 6'b100100), 32'h0000F0F0, 32'h0000FF00,
                 mk(1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b000, 5'd6, 1'b1, 1'b0)};
        v[3] = '{r_type(5'd1, 5'd2, 5'd7, 6'b100101), 32'hA5A5A5A5, 32'h5A5A5A5A,
                 mk(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 5'd7, 1'b1, 1'b0)};
        v[4] = '{r_type(5'd1, 5'd2, 5'd0, 6'b101010), 32'd1, 32'd2,
                 mk(1'b1, 32'd1, 32'd2, 3'b111, 5'd0, 1'b0, 1'b0)};
        v[5] = '{i_type(6'b001001, 5'd0, 5'd4, 16'hFFFF), 32'd0, 32'hDEADBEEF,
                 mk(1'b1, 32'd0, 32'hFFFFFFFF, 3'b010, 5'd4, 1'b1, 1'b0)};
        v[6] = '{i_type(6'b001101, 5'd1, 5'd8, 16'hFFFF), 32'h12345678, 32'd0,
                 mk(1'b1, 32'h12345678, 32'h0000FFFF, 3'b001, 5'd8, 1'b1, 1'b0)};
        v[7] = '{i_type(6'b001010, 5'd1, 5'd9, 16'h8000), 32'h00000011, 32'd0,
                 mk(1'b1, 32'h00000011, 32'hFFFF8000, 3'b111, 5'd9, 1'b1, 1'b0)};
        v[8] = '{i_type(6'b001100, 5'd1, 5'd10, 16'h8000), 32'hFFFFFFFF, 32'd0,
                 mk(1'b1, 32'hFFFFFFFF, 32'h00008000, 3'b000, 5'd10, 1'b1, 1'b0)};
        v[9] = '{r_type(5'd1, 5'd2, 5'd11, 6'b000000), 32'd9, 32'd9,
                 mk(1'b1, 32'd0, 32'd0, 3'b010, 5'd0, 1'b0, 1'b1)};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, v[i].inst, v[i].rs, v[i].rt, 1'b1);
            @(posedge clk);
            #1;
            tests_run++;
            if (obs !== v[i].exp) begin
                tests_failed++;
                $display("FAIL stream_%0d got=%h want=%h", i, obs, v[i].exp);
            end
            $display("[TB] stream %0d inst=%h head=%h", i, v[i].inst, obs);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        tests_run++;
        if (obs !== 75'd0) begin
            tests_failed++;
            $display("FAIL stream_drain got=%h want=%h", obs, 75'd0);
        end
    endtask

    task automatic test_stall();
        logic [74:0] e1, e2, e3;
        e1 = mk(1'b1, 32'd1, 32'd11, 3'b010, 5'd1, 1'b1, 1'b0);
        e2 = mk(1'b1, 32'd2, 32'd22, 3'b110, 5'd2, 1'b1, 1'b0);
        e3 = mk(1'b1, 32'd3, 32'd33, 3'b001, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, r_type(5'd1, 5'd2, 5'd1, 6'b100000), 32'd1, 32'd11, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (obs !== e1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_first got=%h rdy=%b want=%h rdy=1", obs, in_ready, e1);
        end
        @(negedge clk);
        drive(1'b1, r_type(5'd1, 5'd2, 5'd2, 6'b100011), 32'd2, 32'd22, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (obs !== e1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_full got=%h rdy=%b want=%h rdy=0", obs, in_ready, e1);
        end
        @(negedge clk);
        drive(1'b1, r_type(5'd1, 5'd2, 5'd3, 6'b100101), 32'd3, 32'd33, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (obs !== e1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold got=%h rdy=%b want=%h rdy=0", obs, in_ready, e1);
        end
        $display("[TB] stall holding head=%h", obs);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (obs !== e2 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_pop1 got=%h rdy=%b want=%h rdy=1", obs, in_ready, e2);
        end
        @(posedge clk); #1;
        tests_run++;
        if (obs !== e3) begin
            tests_failed++;
            $display("FAIL stall_pushpop got=%h want=%h", obs, e3);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (obs !== 75'd0) begin
            tests_failed++;
            $display("FAIL stall_empty got=%h want=%h", obs, 75'd0);
        end
        $display("[TB] stall drained");
    endtask

    task automatic test_flush();
        logic [74:0] eil;
        eil = mk(1'b1, 32'd0, 32'd0, 3'b010, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'hFC221800, 32'd77, 32'd88, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (obs !== eil) begin
            tests_failed++;
            $display("FAIL flush_illegal got=%h want=%h", obs, eil);
        end
        @(negedge clk);
        drive(1'b1, r_type(5'd1, 5'd2, 5'd3, 6'b100000), 32'd4, 32'd4, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (obs !== 75'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_clear got=%h rdy=%b want=%h rdy=1", obs, in_ready, 75'd0);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        $display("[TB] flush done");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, i_type(6'b001001, 5'd1, 5'd2, 16'h0001), 32'd1, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_fill rdy=%b vld=%b want 0/1", in_ready, out_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (obs !== 75'd0) begin
            tests_failed++;
            $display("FAIL areset_immediate got=%h want=%h", obs, 75'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || obs !== 75'd0) begin
            tests_failed++;
            $display("FAIL areset_release rdy=%b got=%h want rdy=1 %h", in_ready, obs, 75'd0);
        end
        $display("[TB] async reset done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
